// File: rtl/mole_sprite_drawer.sv
// mole_sprite_drawer
//   Repaints the three mole holes on a VGA framebuffer. Each cycle the
//   requested hole levels (gated by game) are registered as the target; the
//   FSM compares target against what was last fully painted and sweeps one
//   MOLE_W x MOLE_H sprite per mismatched hole, lowest index first.
// Ports
//   clock      rising-edge clock
//   resetn     asynchronous active-low reset
//   game       game enable; low requests every hole empty
//   mole[2:0]  per-hole level request (bit i = hole i)
//   x[7:0]     pixel column (holds last value outside a sweep)
//   y[6:0]     pixel row (holds last value outside a sweep)
//   colour     pixel colour, MOLE_COLOUR or black during a sweep, else 0
//   plot       pixel write strobe, high for every sweep cycle
//   busy       high while sweeping or finishing a sweep
//   hole_done  one-cycle pulse on bit i when hole i's sweep completes
module mole_sprite_drawer #(
   parameter int unsigned MOLE_W      = 8,
   parameter int unsigned MOLE_H      = 8,
   parameter int unsigned X0          = 1,
   parameter int unsigned X1          = 9,
   parameter int unsigned X2          = 17,
   parameter int unsigned Y_TOP       = 33,
   parameter logic [2:0]  MOLE_COLOUR = 3'b100
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       game,
   input  logic [2:0] mole,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic [2:0] hole_done
);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   localparam logic [3:0] COL_LAST = 4'(MOLE_W - 1);
   localparam logic [3:0] ROW_LAST = 4'(MOLE_H - 1);
   localparam logic [7:0] X0_L     = 8'(X0);
   localparam logic [7:0] X1_L     = 8'(X1);
   localparam logic [7:0] X2_L     = 8'(X2);
   localparam logic [6:0] Y_TOP_L  = 7'(Y_TOP);

   state_t     state_q, state_d;
   logic [2:0] target_q;
   logic [2:0] shown_q, shown_d;
   logic [1:0] hole_q, hole_d;
   logic       paint_on_q, paint_on_d;
   logic [3:0] col_q, col_d;
   logic [3:0] row_q, row_d;
   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;

   logic [2:0] diff;
   logic [7:0] x_base;
   logic [7:0] x_pix;
   logic [6:0] y_pix;

   assign diff = target_q ^ shown_q;

   always_comb begin
      unique case (hole_q)
         2'd0:    x_base = X0_L;
         2'd1:    x_base = X1_L;
         default: x_base = X2_L;
      endcase
   end

   assign x_pix = x_base + {4'b0000, col_q};
   assign y_pix = Y_TOP_L + {3'b000, row_q};

   always_comb begin
      state_d    = state_q;
      shown_d    = shown_q;
      hole_d     = hole_q;
      paint_on_d = paint_on_q;
      col_d      = col_q;
      row_d      = row_q;
      x_d        = x_q;
      y_d        = y_q;
      plot       = 1'b0;
      colour     = '0;
      busy       = 1'b1;
      hole_done  = '0;
      x          = x_q;
      y          = y_q;

      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (diff != 3'b000) begin
               if (diff[0]) begin
                  hole_d     = 2'd0;
                  paint_on_d = target_q[0];
               end else if (diff[1]) begin
                  hole_d     = 2'd1;
                  paint_on_d = target_q[1];
               end else begin
                  hole_d     = 2'd2;
                  paint_on_d = target_q[2];
               end
               col_d   = '0;
               row_d   = '0;
               state_d = SWEEP;
            end
         end
         SWEEP: begin
            plot   = 1'b1;
            colour = paint_on_q ? MOLE_COLOUR : 3'b000;
            x      = x_pix;
            y      = y_pix;
            // Remember the pixel so x/y hold it once the sweep ends.
            x_d    = x_pix;
            y_d    = y_pix;
            if (col_q == COL_LAST) begin
               col_d = '0;
               if (row_q == ROW_LAST) begin
                  state_d = DONE;
               end else begin
                  row_d = row_q + 4'd1;
               end
            end else begin
               col_d = col_q + 4'd1;
            end
         end
         DONE: begin
            shown_d[hole_q]   = paint_on_q;
            hole_done[hole_q] = 1'b1;
            state_d           = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         target_q   <= '0;
         shown_q    <= '0;
         hole_q     <= '0;
         paint_on_q <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
      end else begin
         state_q    <= state_d;
         target_q   <= mole & {3{game}};
         shown_q    <= shown_d;
         hole_q     <= hole_d;
         paint_on_q <= paint_on_d;
         col_q      <= col_d;
         row_q      <= row_d;
         x_q        <= x_d;
         y_q        <= y_d;
      end
   end

endmodule

// File: doc/mole_sprite_drawer.md
MOLE_SPRITE_DRAWER -- requirements
Module: mole_sprite_drawer

Interface
REQ-001 Parameter MOLE_W, default 8, sprite width in pixels (1..16).
REQ-002 Parameter MOLE_H, default 8, sprite height in pixels (1..16).
REQ-003 Parameter X0 / X1 / X2, defaults 1 / 9 / 17, left column of holes 0 / 1 / 2.
REQ-004 Parameter Y_TOP, default 33, top row shared by all holes.
REQ-005 Parameter MOLE_COLOUR, default 3'b100, colour for a visible mole; background is 3'b000.
REQ-006 Port clock, input, 1, single clock (50 MHz); all state changes on its rising edge.
REQ-007 Port resetn, input, 1, asynchronous active-low reset.
REQ-008 Port game, input, 1, game enable; low forces every hole to target "empty".
REQ-009 Port mole, input, 3, level request per hole from the mole display controller (bit i = hole i); multi-hot legal.
REQ-010 Port x, output, 8, pixel column to the VGA adapter.
REQ-011 Port y, output, 7, pixel row to the VGA adapter.
REQ-012 Port colour, output, 3, pixel colour to the VGA adapter.
REQ-013 Port plot, output, 1, pixel write strobe; one pixel per high cycle.
REQ-014 Port busy, output, 1, high while a sweep is in progress.
REQ-015 Port hole_done, output, 3, one-cycle pulse on bit i when hole i's sweep completes.

Function
REQ-016 mole & {3{game}} SHALL be registered into target_q every cycle; no other logic uses the raw inputs.
REQ-017 Internal shown[2:0] SHALL record the colour state last fully painted per hole.
REQ-018 FSM states: IDLE, SWEEP, DONE.
REQ-019 IDLE: if target_q != shown, select lowest index i with target_q[i] != shown[i], latch paint_on = target_q[i], reset col = row = 0, go SWEEP; else stay in IDLE.
REQ-020 SWEEP: plot = 1, x = Xi + col, y = Y_TOP + row, colour = paint_on ? MOLE_COLOUR : 3'b000; col increments each cycle, wraps to 0 at MOLE_W-1 and increments row.
REQ-021 SWEEP SHALL last exactly MOLE_W*MOLE_H cycles, row-major, no skipped or repeated pixel; after the pixel (MOLE_W-1, MOLE_H-1) go DONE.
REQ-022 DONE (one cycle): plot = 0, shown[i] <= paint_on, hole_done[i] = 1, go IDLE.
REQ-023 Latency: input change before rising edge k -> target_q updates at k -> FSM enters SWEEP at k+1 -> first plot-high cycle is between k+1 and k+2.
REQ-024 Input changes during SWEEP SHALL NOT alter the latched hole or paint_on; they are compared in the next IDLE cycle.
REQ-025 A request that toggles on then off within one sweep SHALL produce no extra sweep if target_q equals shown at the next IDLE.
REQ-026 Multiple mismatched holes SHALL be served one per sweep in ascending index order, with one IDLE cycle between sweeps.
REQ-027 game falling during SWEEP SHALL complete the current sweep, then erase every hole with shown = 1.
REQ-028 Outside SWEEP: plot = 0, colour = 3'b000; x and y hold their last values.
REQ-029 busy SHALL be high in SWEEP and DONE, low in IDLE.
REQ-030 Pixel arithmetic SHALL be unsigned 8-bit (x) / 7-bit (y); parameters are constrained so that no sum exceeds 159 / 119.

Reset
REQ-031 resetn low SHALL immediately force state IDLE, target_q = shown = 3'b000, col = row = 0, x = 0, y = 0, colour = 0, plot = 0, busy = 0, hole_done = 0.
REQ-032 Reset during SWEEP SHALL abort the sweep with no further plot; the partial sprite is not erased.
REQ-033 After resetn rises, the first sweep SHALL start no earlier than the second rising edge.

Verification
REQ-034 Reset, game = 1, mole = 3'b010 -> exactly 64 plot cycles with colour 3'b100, x 9..16, y 33..40 row-major, then hole_done = 3'b010 for one cycle.
REQ-035 With hole 1 shown, mole -> 3'b000 -> 64 plot cycles at x 9..16, y 33..40 with colour 3'b000, then shown = 3'b000.
REQ-036 mole = 3'b101 from idle -> hole 0 sweep (x 1..8), one IDLE cycle, hole 2 sweep (x 17..24); 128 plot cycles total.
REQ-037 mole 3'b001 -> 3'b000 at pixel 20 of the hole 0 draw -> the draw completes all 64 pixels in red, then 64 black pixels at x 1..8.
REQ-038 game = 0 while mole = 3'b111 is shown -> three erase sweeps, holes 0, 1, 2, busy high throughout except the inter-sweep IDLE cycles.
REQ-039 resetn pulsed low at pixel 30 -> plot = 0 in the same cycle, all outputs 0, no sweep until mole differs from 3'b000.
